// File: rtl/fir_serial_ctrl.sv
// fir_serial_ctrl: sequencer for a single-MAC serial FIR datapath.
// Optional macro FIR_CTRL_OVF_EN adds a saturating dropped-sample counter.
module fir_serial_ctrl #(
    parameter  int Num_coef = 17,
    parameter  int Pipe_lat = 2,
    localparam int SEL_W    = $clog2(Num_coef)
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef FIR_CTRL_OVF_EN
    input  logic             ovf_clr,
    output logic [7:0]       ovf_cnt,
`endif
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             shift_ce,
    output logic [SEL_W-1:0] sel,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             dout_valid,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_MAC,
        S_DRAIN,
        S_OUT
    } state_t;

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(Num_coef - 1);
    localparam logic [2:0]       DRN_LAST = 3'(Pipe_lat > 0 ? Pipe_lat - 1 : 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [2:0]       r_dcnt;
    logic [2:0]       w_dcnt_nxt;
    logic             r_shift_ce;
    logic             r_acc_clr;
    logic             r_acc_en;
    logic             r_dout_valid;

    // Next state plus next tap/drain counts; counters idle at zero.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = '0;
        w_dcnt_nxt  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (sample_valid) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_state_nxt = S_MAC;
            end
            S_MAC: begin
                if (r_sel == SEL_LAST) begin
                    w_state_nxt = (Pipe_lat == 0) ? S_OUT : S_DRAIN;
                end else begin
                    w_sel_nxt = r_sel + SEL_W'(1);
                end
            end
            S_DRAIN: begin
                if (r_dcnt == DRN_LAST) begin
                    w_state_nxt = S_OUT;
                end else begin
                    w_dcnt_nxt = r_dcnt + 3'd1;
                end
            end
            S_OUT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; strobes are registered from the next state so
    // they line up exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sel        <= '0;
            r_dcnt       <= '0;
            r_shift_ce   <= 1'b0;
            r_acc_clr    <= 1'b0;
            r_acc_en     <= 1'b0;
            r_dout_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_dcnt       <= w_dcnt_nxt;
            r_shift_ce   <= (w_state_nxt == S_SHIFT);
            r_acc_clr    <= (w_state_nxt == S_MAC) && (w_sel_nxt == '0);
            r_acc_en     <= (w_state_nxt == S_MAC) ||
                            (w_state_nxt == S_DRAIN);
            r_dout_valid <= (w_state_nxt == S_OUT);
        end
    end

    assign sample_ready = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign shift_ce     = r_shift_ce;
    assign sel          = r_sel;
    assign acc_clr      = r_acc_clr;
    assign acc_en       = r_acc_en;
    assign dout_valid   = r_dout_valid;

`ifdef FIR_CTRL_OVF_EN
    logic       w_drop;
    logic [7:0] r_ovf;

    assign w_drop  = sample_valid & ~sample_ready;
    assign ovf_cnt = r_ovf;

    // Saturating drop counter; clear has priority over a same-cycle drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 8'd0;
        end else if (ovf_clr) begin
            r_ovf <= 8'd0;
        end else if (w_drop && (r_ovf != 8'hFF)) begin
            r_ovf <= r_ovf + 8'd1;
        end
    end
`endif

endmodule
